// File: rtl/br_pkg.sv
// Shared definitions for the register bank write-port arbiter.
// Holds bank geometry, the sequencer state type and a small address helper.
package br_pkg;

  localparam int BR_ADDR_W   = 5;
  localparam int BR_DATA_W   = 32;
  localparam int BR_NUM_REGS = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } br_wr_state_t;

  // Register 0 is hard-wired to zero in the bank, so writes to it are dropped.
  function automatic logic br_is_write(input logic [BR_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/br_write_arbiter_if.sv
// Writeback-side and bank-side signals of the register bank write port.
// master: the writeback requesters and the bank; slave: the arbiter itself.
interface br_write_arbiter_if;
  import br_pkg::*;

  logic                 a_valid;
  logic [BR_ADDR_W-1:0] a_addr;
  logic [BR_DATA_W-1:0] a_data;
  logic                 a_ready;

  logic                 b_valid;
  logic [BR_ADDR_W-1:0] b_addr;
  logic [BR_DATA_W-1:0] b_data;
  logic                 b_ready;

  logic [BR_ADDR_W-1:0] Write_Reg;
  logic [BR_DATA_W-1:0] Write_Data;
  logic                 RegWrite;
  logic                 busy;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output Write_Reg, Write_Data, RegWrite, busy
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  Write_Reg, Write_Data, RegWrite, busy
  );

endinterface

// File: rtl/br_clear_seq.sv
// Index generator for the post-reset bank clear: walks registers 1..31.
// Only instantiated when BR_CLEAR_ON_RESET_EN is defined.
module br_clear_seq
  import br_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [BR_ADDR_W-1:0] index,
  output logic                 done
);

  // Advance through the register indices while the clear is running; restart at 1 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= BR_ADDR_W'(1);
    end else if (en) begin
      index <= index + BR_ADDR_W'(1);
    end
  end

  assign done = (index == BR_ADDR_W'(BR_NUM_REGS - 1));

endmodule

// File: rtl/br_write_arbiter.sv
// Write-port sequencer/arbiter for the 32x32 register bank.
// Requester A (ALU) is preferred over B (load) unless B has waited STARVE_LIMIT
// cycles. Writes to register 0 complete the handshake but never reach the bank.
// Optional feature macro: BR_CLEAR_ON_RESET_EN (zero registers 1..31 after reset).
module br_write_arbiter
  import br_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)
(
  input  logic               clk,
  input  logic               rst_n,
  br_write_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]           starve_cnt;
  logic                 a_rdy;
  logic                 b_rdy;
  logic                 in_run;
  logic                 reg_write;
  logic [BR_ADDR_W-1:0] write_reg;
  logic [BR_DATA_W-1:0] write_data;
  br_wr_state_t         state;

`ifdef BR_CLEAR_ON_RESET_EN
  logic [BR_ADDR_W-1:0] clr_index;
  logic                 clr_done;

  br_clear_seq u_clear_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == CLEAR),
    .index (clr_index),
    .done  (clr_done)
  );
`else
  assign state = RUN;
`endif

  assign in_run = (state == RUN);

  // Grant logic: A by default, B when it has starved; nothing while clearing or in reset.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (rst_n && in_run) begin
      if (bus.a_valid && bus.b_valid) begin
        if (starve_cnt == LIMIT) begin
          b_rdy = 1'b1;
        end else begin
          a_rdy = 1'b1;
        end
      end else begin
        a_rdy = bus.a_valid;
        b_rdy = bus.b_valid;
      end
    end
  end

  // Count consecutive cycles B is left waiting; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (in_run && bus.b_valid && !b_rdy) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Sequencer state and registered bank outputs: clear sweep, then granted writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
`ifdef BR_CLEAR_ON_RESET_EN
      state      <= CLEAR;
`endif
    end else begin
`ifdef BR_CLEAR_ON_RESET_EN
      if (state == CLEAR) begin
        reg_write  <= 1'b1;
        write_reg  <= clr_index;
        write_data <= '0;
        if (clr_done) begin
          state <= RUN;
        end
      end else
`endif
      if (a_rdy && br_is_write(bus.a_addr)) begin
        reg_write  <= 1'b1;
        write_reg  <= bus.a_addr;
        write_data <= bus.a_data;
      end else if (b_rdy && br_is_write(bus.b_addr)) begin
        reg_write  <= 1'b1;
        write_reg  <= bus.b_addr;
        write_data <= bus.b_data;
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

  assign bus.a_ready    = a_rdy;
  assign bus.b_ready    = b_rdy;
  assign bus.RegWrite   = reg_write;
  assign bus.Write_Reg  = write_reg;
  assign bus.Write_Data = write_data;
`ifdef BR_CLEAR_ON_RESET_EN
  assign bus.busy       = (state == CLEAR);
`else
  assign bus.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_br_write_arbiter.sv
// Self-checking bench for br_write_arbiter.
// Expected bank writes are queued when a request is driven and popped one cycle later.
// Clear-sequence scenarios are compiled only when BR_CLEAR_ON_RESET_EN is defined.
module tb_br_write_arbiter;
  import br_pkg::*;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  exp_t        sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [4:0]  mdl_reg      = '0;
  logic [31:0] mdl_data     = '0;

`ifdef BR_CLEAR_ON_RESET_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  // Free-running clock
  always #5 clk = ~clk;

  br_write_arbiter_if bus();

  br_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
  endtask

  // Model of the bank outputs one edge after an (optional) acceptance.
  task automatic push_expect(input logic acc, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    if (acc && addr != 5'd0) begin
      mdl_reg  = addr;
      mdl_data = data;
      e.we     = 1'b1;
    end else begin
      e.we     = 1'b0;
    end
    e.addr = mdl_reg;
    e.data = mdl_data;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
    #1 rst_n = 1'b0;
    #2;
    tests_run++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got a=%b b=%b expected a=0 b=0", bus.a_ready, bus.b_ready);
    end
    tests_run++;
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== 38'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got we=%b reg=%0d data=%h expected all zero",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data);
    end
    tests_run++;
    if (bus.busy !== EXP_BUSY_RST) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b expected %b", bus.busy, EXP_BUSY_RST);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
  endtask

`ifdef BR_CLEAR_ON_RESET_EN
  task automatic test_clear;
    drive(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      tick;
      tests_run++;
      if (bus.RegWrite !== 1'b1 || bus.Write_Reg !== 5'(i) || bus.Write_Data !== 32'd0 ||
          bus.busy !== 1'b1 || bus.a_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL clear_pre_%0d: got we=%b reg=%0d data=%h busy=%b a_ready=%b expected 1 %0d 0 1 0",
                 i, bus.RegWrite, bus.Write_Reg, bus.Write_Data, bus.busy, bus.a_ready, i);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== 38'd0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_reset: got we=%b reg=%0d data=%h busy=%b expected 0 0 0 1",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, bus.busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick;
      tests_run++;
      if (bus.RegWrite !== 1'b1 || bus.Write_Reg !== 5'(i) || bus.Write_Data !== 32'd0 ||
          bus.busy !== (i < 31)) begin
        tests_failed++;
        $display("[TB] FAIL clear_%0d: got we=%b reg=%0d data=%h busy=%b expected 1 %0d 0 %b",
                 i, bus.RegWrite, bus.Write_Reg, bus.Write_Data, bus.busy, i, (i < 31));
      end
    end
    tests_run++;
    if (bus.a_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_first_accept: got a_ready=%b expected 1", bus.a_ready);
    end
    mdl_reg  = 5'd31;
    mdl_data = 32'd0;
    push_expect(1'b1, 5'd0, 32'h0);
    tick;
    begin
      exp_t e;
      tests_run++;
      e = sb.pop_front();
      if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
        tests_failed++;
        $display("[TB] FAIL clear_after: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                 bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
      end
    end
  endtask
`endif

  task automatic test_single_a;
    exp_t e;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    tests_run++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_a_ready: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
    push_expect(1'b1, 5'd5, 32'hDEADBEEF);
    tick;
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL single_a_out: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
  endtask

  task automatic test_single_b;
    exp_t e;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000CAFE);
    #1;
    tests_run++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_b_ready: got a=%b b=%b expected a=0 b=1", bus.a_ready, bus.b_ready);
    end
    push_expect(1'b1, 5'd9, 32'h0000CAFE);
    tick;
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL single_b_out: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
  endtask

  // Both requesters continuously valid: A four times, then B, repeating.
  task automatic test_starvation;
    logic [9:0]  pat;
    logic        exp_b;
    logic [31:0] ad;
    logic [31:0] bd;
    exp_t        e;
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      ad = 32'hA000_0000 + 32'(i);
      bd = 32'hB000_0000 + 32'(i);
      drive(1'b1, 5'd3, ad, 1'b1, 5'd4, bd);
      #1;
      exp_b = pat[i];
      tests_run++;
      if (bus.a_ready !== ~exp_b || bus.b_ready !== exp_b) begin
        tests_failed++;
        $display("[TB] FAIL starve_grant_%0d: got a=%b b=%b expected a=%b b=%b",
                 i, bus.a_ready, bus.b_ready, ~exp_b, exp_b);
      end
      push_expect(1'b1, exp_b ? 5'd4 : 5'd3, exp_b ? bd : ad);
      tick;
      tests_run++;
      e = sb.pop_front();
      if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
        tests_failed++;
        $display("[TB] FAIL starve_out_%0d: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                 i, bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
      end
    end
  endtask

  // B withdraws after three losses; its wait count must start over.
  task automatic test_starve_clear;
    logic [8:0] bv;
    logic [8:0] exp_bg;
    exp_t       e;
    bv     = 9'b111110111;
    exp_bg = 9'b100000000;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'd10, 32'hC000_0000 + 32'(i), bv[i], 5'd11, 32'hD000_0000 + 32'(i));
      #1;
      tests_run++;
      if (bus.a_ready !== ~exp_bg[i] || bus.b_ready !== exp_bg[i]) begin
        tests_failed++;
        $display("[TB] FAIL starve_clear_%0d: got a=%b b=%b expected a=%b b=%b",
                 i, bus.a_ready, bus.b_ready, ~exp_bg[i], exp_bg[i]);
      end
      push_expect(1'b1, exp_bg[i] ? 5'd11 : 5'd10,
                  exp_bg[i] ? 32'hD000_0000 + 32'(i) : 32'hC000_0000 + 32'(i));
      tick;
      tests_run++;
      e = sb.pop_front();
      if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
        tests_failed++;
        $display("[TB] FAIL starve_clear_out_%0d: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                 i, bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_same_reg;
    exp_t e;
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    #1;
    tests_run++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL same_reg_a: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
    push_expect(1'b1, 5'd7, 32'h11);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22);
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL same_reg_first: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
    #1;
    tests_run++;
    if (bus.b_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL same_reg_b: got b_ready=%b expected 1", bus.b_ready);
    end
    push_expect(1'b1, 5'd7, 32'h22);
    tick;
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL same_reg_second: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
  endtask

  // Register 0 writes handshake but leave the bank outputs untouched.
  task automatic test_addr_zero;
    exp_t e;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    #1;
    tests_run++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_b_ready: got a=%b b=%b expected a=0 b=1", bus.a_ready, bus.b_ready);
    end
    push_expect(1'b1, 5'd0, 32'h1234);
    tick;
    drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0);
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL zero_b_out: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
    #1;
    tests_run++;
    if (bus.a_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_a_ready: got a_ready=%b expected 1", bus.a_ready);
    end
    push_expect(1'b1, 5'd0, 32'h5555);
    tick;
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL zero_a_out: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
  endtask

  task automatic test_idle;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd1, 32'hFFFF_FFFF, 1'b0, 5'd2, 32'hEEEE_EEEE);
      #1;
      tests_run++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_ready_%0d: got a=%b b=%b expected a=0 b=0", i, bus.a_ready, bus.b_ready);
      end
      push_expect(1'b0, 5'd0, 32'h0);
      tick;
      tests_run++;
      e = sb.pop_front();
      if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
        tests_failed++;
        $display("[TB] FAIL idle_out_%0d: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                 i, bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    drive(1'b1, 5'd12, 32'hFACE_0012, 1'b0, 5'd0, 32'h0);
    push_expect(1'b1, 5'd12, 32'hFACE_0012);
    tick;
    tests_run++;
    e = sb.pop_front();
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_write: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== 38'd0 || bus.a_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_reset: got we=%b reg=%0d data=%h a_ready=%b expected all zero",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, bus.a_ready);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    mdl_reg  = '0;
    mdl_data = '0;
    tick;
`ifdef BR_CLEAR_ON_RESET_EN
    e.we   = 1'b1;
    e.addr = 5'd1;
    e.data = 32'd0;
`else
    e.we   = 1'b0;
    e.addr = 5'd0;
    e.data = 32'd0;
`endif
    tests_run++;
    if ({bus.RegWrite, bus.Write_Reg, bus.Write_Data} !== {e.we, e.addr, e.data}) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_restart: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
               bus.RegWrite, bus.Write_Reg, bus.Write_Data, e.we, e.addr, e.data);
    end
  endtask

  // Scenario sequence
  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset;
`ifdef BR_CLEAR_ON_RESET_EN
    test_clear;
`endif
    test_single_a;
    test_single_b;
    test_starvation;
    test_starve_clear;
    test_same_reg;
    test_addr_zero;
    test_idle;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Run-time bound
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
